// File: rtl/encoder_pri_irq_if.sv
// Request/grant bundle between raw request lines and the encoder core.
// The master side drives requests, mask, enable and ack; the slave side returns the grant.
// The names keep the legacy encoder pin names so existing boards map one to one.
interface encoder_pri_irq_if #(
  parameter int N = 8
);
  localparam int W = $clog2(N);

  logic         iEI;
  logic [N-1:0] iData;
  logic [N-1:0] iMask;
  logic         iAck;
  logic [W-1:0] oData;
  logic         oValid;
  logic         oEO;
  logic [N-1:0] oPend;

  modport master (
    output iEI, iData, iMask, iAck,
    input  oData, oValid, oEO, oPend
  );

  modport slave (
    input  iEI, iData, iMask, iAck,
    output oData, oValid, oEO, oPend
  );
endinterface

// File: rtl/encoder_pri_irq.sv
// Registered priority encoder: latches active-low requests, grants one channel at a time.
// Latency: request at edge t is pending after t, and the grant is visible after edge t+1.
// Backpressure: a grant is held until iAck; requests keep accumulating in the pending register.
module encoder_pri_irq #(
  parameter int N    = 8,
  parameter int RR   = 0,
  parameter int EDGE = 0
) (
  input  logic              iClk,
  input  logic              iRst,
  encoder_pri_irq_if.slave  bus
);
  localparam int W = $clog2(N);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t       state_q, state_d;
  logic [N-1:0] pend_q, pend_d;
  logic [N-1:0] prev_q, prev_d;
  logic [W-1:0] ptr_q, ptr_d;
  logic [W-1:0] data_q, data_d;
  logic         eo_q, eo_d;

  logic [N-1:0] req;
  logic [N-1:0] clr;
  logic [N-1:0] elig;
  logic [W-1:0] win;

  // Request decode: input bit N-1-c belongs to channel c; edge mode needs a high-to-low step.
  always_comb begin
    req = '0;
    for (int c = 0; c < N; c++) begin
      if (EDGE != 0) req[c] = prev_q[N-1-c] & ~bus.iData[N-1-c];
      else           req[c] = ~bus.iData[N-1-c];
    end
  end

  // Pending update: the serviced channel clears on ack, but a same-cycle request re-sets it.
  always_comb begin
    clr = '0;
    if (state_q == GRANT && bus.iAck) clr[data_q] = 1'b1;
    pend_d = (pend_q & ~clr) | req;
    prev_d = bus.iData;
    elig   = pend_q & ~bus.iMask;
  end

  // Winner search from the registered pending set; the descending loop lets the nearest offset win.
  always_comb begin
    int idx;
    win = '0;
    idx = 0;
    for (int i = N - 1; i >= 0; i--) begin
      idx = (RR != 0) ? ((int'(ptr_q) + i) % N) : i;
      if (elig[idx]) win = W'(idx);
    end
  end

  // Grant sequencing, rotation pointer and the registered enable-out flag.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    ptr_d   = ptr_q;
    case (state_q)
      IDLE: begin
        if (!bus.iEI && (elig != '0)) begin
          state_d = GRANT;
          data_d  = win;
        end
      end
      GRANT: begin
        if (bus.iAck) begin
          state_d = IDLE;
          ptr_d   = (data_q == W'(N - 1)) ? '0 : data_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    eo_d = ~(~bus.iEI & ((pend_d & ~bus.iMask) == '0) & (state_d == IDLE));
  end

  // All state lives here; reset drops any outstanding grant without waiting for ack.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      state_q <= IDLE;
      pend_q  <= '0;
      prev_q  <= '1;
      ptr_q   <= '0;
      data_q  <= '0;
      eo_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      prev_q  <= prev_d;
      ptr_q   <= ptr_d;
      data_q  <= data_d;
      eo_q    <= eo_d;
    end
  end

  assign bus.oValid = (state_q == GRANT);
  assign bus.oData  = data_q;
  assign bus.oEO    = eo_q;
  assign bus.oPend  = pend_q;
endmodule

// File: tb/tb_encoder_pri_irq.sv
// Directed checks of the registered priority encoder in fixed, round-robin and edge modes.
// Outputs are sampled 1 time unit after each rising edge; inputs change at that point too.
// A vector table covers the fixed-priority core; short sequences cover multi-cycle cases.
module tb_encoder_pri_irq;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  encoder_pri_irq_if #(.N(8)) fx_if ();
  encoder_pri_irq_if #(.N(8)) rr_if ();
  encoder_pri_irq_if #(.N(8)) ed_if ();

  encoder_pri_irq #(.N(8), .RR(0), .EDGE(0)) u_fx (.iClk(clk), .iRst(rst), .bus(fx_if));
  encoder_pri_irq #(.N(8), .RR(1), .EDGE(0)) u_rr (.iClk(clk), .iRst(rst), .bus(rr_if));
  encoder_pri_irq #(.N(8), .RR(0), .EDGE(1)) u_ed (.iClk(clk), .iRst(rst), .bus(ed_if));

  typedef struct {
    logic       rst;
    logic       ei;
    logic [7:0] data;
    logic [7:0] mask;
    logic       ack;
    logic       v;
    logic [2:0] d;
    logic       eo;
    logic [7:0] p;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic r, input logic ei, input logic [7:0] dat, input logic [7:0] msk,
                     input logic ack, input logic v, input logic [2:0] d, input logic eo,
                     input logic [7:0] p);
    vec_t t;
    t.rst = r; t.ei = ei; t.data = dat; t.mask = msk; t.ack = ack;
    t.v = v; t.d = d; t.eo = eo; t.p = p;
    tbl.push_back(t);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_bit(input string name, input logic got, input logic want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %b want %b", name, got, want);
    end
  endtask

  task automatic check_int(input string name, input int got, input int want);
    n_vec++;
    if (got != want) begin
      n_err++;
      $display("FAIL %s: got %0d want %0d", name, got, want);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int rr_got[$];
    int fx_got[$];
    int rr_exp[4];
    int fx_exp[3];
    int g;
    int bad_code;
    logic seen;

    fx_if.iEI = 1'b0; fx_if.iData = 8'hFF; fx_if.iMask = 8'h00; fx_if.iAck = 1'b0;
    rr_if.iEI = 1'b0; rr_if.iData = 8'hFF; rr_if.iMask = 8'h00; rr_if.iAck = 1'b0;
    ed_if.iEI = 1'b0; ed_if.iData = 8'hFF; ed_if.iMask = 8'h00; ed_if.iAck = 1'b0;

    // rst ei data mask ack | valid data eo pend
    add(1, 0, 8'h00, 8'h00, 0, 0, 0, 1, 8'h00);
    add(1, 0, 8'h00, 8'h00, 0, 0, 0, 1, 8'h00);
    add(0, 0, 8'h00, 8'h00, 0, 0, 0, 1, 8'hFF);
    add(0, 0, 8'hFF, 8'h00, 0, 1, 0, 1, 8'hFF);
    add(1, 0, 8'hFF, 8'h00, 0, 0, 0, 1, 8'h00);
    add(0, 0, 8'hD7, 8'h00, 0, 0, 0, 1, 8'h14);
    add(0, 0, 8'hFF, 8'h00, 0, 1, 2, 1, 8'h14);
    add(0, 0, 8'hFF, 8'h00, 1, 0, 2, 1, 8'h10);
    add(0, 0, 8'hFF, 8'h00, 0, 1, 4, 1, 8'h10);
    add(0, 0, 8'hFF, 8'h00, 1, 0, 4, 0, 8'h00);
    add(0, 0, 8'hFF, 8'h00, 1, 0, 4, 0, 8'h00);
    add(0, 0, 8'hD7, 8'h04, 0, 0, 4, 1, 8'h14);
    add(0, 0, 8'hFF, 8'h04, 0, 1, 4, 1, 8'h14);
    add(0, 0, 8'hFF, 8'h04, 1, 0, 4, 0, 8'h04);
    add(0, 0, 8'hFF, 8'h04, 0, 0, 4, 0, 8'h04);
    add(0, 0, 8'hFF, 8'h00, 0, 1, 2, 1, 8'h04);
    add(0, 0, 8'hFF, 8'h00, 1, 0, 2, 0, 8'h00);
    add(0, 1, 8'hEF, 8'h00, 0, 0, 2, 1, 8'h08);
    add(0, 1, 8'hFF, 8'h00, 0, 0, 2, 1, 8'h08);
    add(0, 0, 8'hFF, 8'h00, 0, 1, 3, 1, 8'h08);
    add(0, 1, 8'hFF, 8'h00, 0, 1, 3, 1, 8'h08);
    add(0, 1, 8'hFF, 8'h08, 0, 1, 3, 1, 8'h08);
    add(0, 1, 8'hFF, 8'h00, 1, 0, 3, 1, 8'h00);
    add(0, 0, 8'hFF, 8'h00, 0, 0, 3, 0, 8'h00);
    add(0, 0, 8'hEF, 8'h00, 0, 0, 3, 1, 8'h08);
    add(0, 0, 8'hEF, 8'h00, 0, 1, 3, 1, 8'h08);
    add(0, 0, 8'hEF, 8'h00, 1, 0, 3, 1, 8'h08);
    add(0, 0, 8'hFF, 8'h00, 0, 1, 3, 1, 8'h08);
    add(0, 0, 8'hFF, 8'h00, 1, 0, 3, 0, 8'h00);
    add(0, 0, 8'hFE, 8'h00, 0, 0, 3, 1, 8'h80);
    add(0, 0, 8'hFF, 8'h00, 0, 1, 7, 1, 8'h80);
    add(0, 0, 8'hFF, 8'h00, 1, 0, 7, 0, 8'h00);

    for (int i = 0; i < tbl.size(); i++) begin
      rst = tbl[i].rst;
      fx_if.iEI = tbl[i].ei; fx_if.iData = tbl[i].data;
      fx_if.iMask = tbl[i].mask; fx_if.iAck = tbl[i].ack;
      tick();
      n_vec++;
      if (fx_if.oValid !== tbl[i].v || fx_if.oData !== tbl[i].d ||
          fx_if.oEO !== tbl[i].eo || fx_if.oPend !== tbl[i].p) begin
        n_err++;
        $display("FAIL vec%0d: valid/data/eo/pend got %b/%0d/%b/%h want %b/%0d/%b/%h", i,
                 fx_if.oValid, fx_if.oData, fx_if.oEO, fx_if.oPend,
                 tbl[i].v, tbl[i].d, tbl[i].eo, tbl[i].p);
      end
    end
    fx_if.iEI = 1'b0; fx_if.iData = 8'hFF; fx_if.iMask = 8'h00; fx_if.iAck = 1'b0;

    // Channels 1 and 6 held low; round-robin alternates, fixed priority sticks to 1.
    rst = 1'b1; tick(); tick(); rst = 1'b0;
    rr_if.iData = 8'hBD; fx_if.iData = 8'hBD;
    rr_exp = '{1, 6, 1, 6};
    fx_exp = '{1, 1, 1};
    for (int cyc = 0; cyc < 40 && (rr_got.size() < 4 || fx_got.size() < 3); cyc++) begin
      tick();
      if (rr_if.oValid && !rr_if.iAck) begin
        if (rr_got.size() < 4) rr_got.push_back(int'(rr_if.oData));
        rr_if.iAck = 1'b1;
      end else rr_if.iAck = 1'b0;
      if (fx_if.oValid && !fx_if.iAck) begin
        if (fx_got.size() < 3) fx_got.push_back(int'(fx_if.oData));
        fx_if.iAck = 1'b1;
      end else fx_if.iAck = 1'b0;
    end
    for (int i = 0; i < 4; i++)
      check_int($sformatf("rr_grant%0d", i), (i < rr_got.size()) ? rr_got[i] : -1, rr_exp[i]);
    for (int i = 0; i < 3; i++)
      check_int($sformatf("fx_grant%0d", i), (i < fx_got.size()) ? fx_got[i] : -1, fx_exp[i]);
    rr_if.iData = 8'hFF; fx_if.iData = 8'hFF;
    tick();
    rr_if.iAck = 1'b0; fx_if.iAck = 1'b0;

    // Edge mode: a held-low line yields one grant; release and re-assert yields one more.
    rst = 1'b1; tick(); tick(); rst = 1'b0;
    g = 0; bad_code = 0;
    ed_if.iData = 8'h7F;
    for (int cyc = 0; cyc < 10; cyc++) begin
      tick();
      if (ed_if.oValid && !ed_if.iAck) begin
        g++;
        if (ed_if.oData != 3'd0) bad_code++;
        ed_if.iAck = 1'b1;
      end else ed_if.iAck = 1'b0;
    end
    check_int("edge_hold_grants", g, 1);
    check_int("edge_hold_code_errs", bad_code, 0);

    ed_if.iData = 8'hFF;
    for (int cyc = 0; cyc < 2; cyc++) begin
      tick();
      ed_if.iAck = 1'b0;
    end
    g = 0;
    ed_if.iData = 8'h7F;
    for (int cyc = 0; cyc < 6; cyc++) begin
      tick();
      if (ed_if.oValid && !ed_if.iAck) begin
        g++;
        ed_if.iAck = 1'b1;
      end else ed_if.iAck = 1'b0;
    end
    check_int("edge_reassert_grants", g, 1);
    ed_if.iAck = 1'b0;

    // Reset during an outstanding edge-mode grant.
    ed_if.iData = 8'hFF;
    tick();
    ed_if.iData = 8'h7F;
    seen = 1'b0;
    for (int cyc = 0; cyc < 6 && !seen; cyc++) begin
      tick();
      if (ed_if.oValid) seen = 1'b1;
    end
    check_bit("edge_grant_before_reset", seen, 1'b1);
    rst = 1'b1;
    tick();
    check_bit("reset_drops_valid", ed_if.oValid, 1'b0);
    check_int("reset_clears_pend", int'(ed_if.oPend), 0);
    tick();
    check_bit("reset_held_valid", ed_if.oValid, 1'b0);
    ed_if.iData = 8'hFF;
    tick();
    rst = 1'b0;
    g = 0;
    for (int cyc = 0; cyc < 5; cyc++) begin
      tick();
      if (ed_if.oValid) g++;
    end
    check_int("no_grant_after_reset", g, 0);
    check_bit("edge_idle_eo", ed_if.oEO, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
